// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU even-pipe result path.
// An rt_entry_t is one in-flight RT result: valid flag, target register, 128-bit data.
package spu_pkg;

    localparam int WIDTH       = 128;
    localparam int ADDR_W      = 7;
    localparam int SF2_LATENCY = 4;

    typedef struct packed {
        logic              valid;
        logic [0:ADDR_W-1] addr;
        logic [0:WIDTH-1]  data;
    } rt_entry_t;

endpackage

// File: rtl/sf2_pipe_stage.sv
// One result-pipe stage: registers an rt_entry_t each edge; kill drops the valid
// bit while addr/data still shift so the datapath needs no enable.
module sf2_pipe_stage
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      kill,
    input  rt_entry_t d,
    output rt_entry_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q.valid <= d.valid & ~kill;
            q.addr  <= d.addr;
            q.data  <= d.data;
        end
    end

endmodule

// File: rtl/sf2_result_pipe.sv
// Fixed-latency writeback pipe for the Simple Fixed 2 unit: every stage is a
// forwarding tap, the last stage drives the register-file write port.
module sf2_result_pipe
    import spu_pkg::*;
#(
    parameter int LATENCY = SF2_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [0:ADDR_W-1]           issue_rt_addr,
    input  logic [0:WIDTH-1]            issue_rt_data,
    input  logic                        flush,
    output logic [LATENCY-1:0]          fwd_valid,
    output logic [LATENCY*ADDR_W-1:0]   fwd_addr,
    output logic [LATENCY*WIDTH-1:0]    fwd_data,
    output logic                        wb_en,
    output logic [0:ADDR_W-1]           wb_addr,
    output logic [0:WIDTH-1]            wb_data,
    output logic [3:0]                  inflight
);

    rt_entry_t          stage_d [LATENCY];
    rt_entry_t          stage_q [LATENCY];
    logic [LATENCY-1:0] next_valid;
    logic [3:0]         inflight_next;
    logic [3:0]         inflight_reg;

    // Flush kills every stage input, including the new issue; the entry that is
    // already in the last stage has been presented this cycle and commits.
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi].valid = issue_valid;
                assign stage_d[gi].addr  = issue_rt_addr;
                assign stage_d[gi].data  = issue_rt_data;
            end else begin : g_body
                assign stage_d[gi] = stage_q[gi-1];
            end

            sf2_pipe_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .kill  (flush),
                .d     (stage_d[gi]),
                .q     (stage_q[gi])
            );

            assign next_valid[gi]                   = stage_d[gi].valid & ~flush;
            assign fwd_valid[gi]                    = stage_q[gi].valid;
            assign fwd_addr[gi*ADDR_W +: ADDR_W]    = stage_q[gi].addr;
            assign fwd_data[gi*WIDTH +: WIDTH]      = stage_q[gi].data;
        end
    endgenerate

    always_comb begin
        inflight_next = '0;
        for (int i = 0; i < LATENCY; i++) begin
            if (next_valid[i]) begin
                inflight_next = inflight_next + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign inflight = inflight_reg;
    assign wb_en    = stage_q[LATENCY-1].valid;
    assign wb_addr  = stage_q[LATENCY-1].addr;
    assign wb_data  = stage_q[LATENCY-1].data;

endmodule
